// File: rtl/spart_pkg.sv
// Shared constants and state encodings for the SPART serial port.
package spart_pkg;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned DIV_W          = 16;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud generator: divisor register with low-byte staging and a down-counter
// that emits a one-cycle oversample tick each time it reaches zero.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter logic [DIV_W-1:0] DIV_RESET = 16'd325
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_dbl,
  input  logic              wr_dbh,
  input  logic [DATA_W-1:0] data,
  output logic [DIV_W-1:0]  divisor,
  output logic              tick_c
);

  logic [DATA_W-1:0] low_stage;
  logic [DIV_W-1:0]  count;

  assign tick_c = (count == '0);

  // High-byte write commits the whole divisor and restarts the count at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor   <= DIV_RESET;
      low_stage <= '0;
      count     <= DIV_RESET;
    end else begin
      if (wr_dbl) low_stage <= data;
      if (wr_dbh) begin
        divisor <= {data, low_stage};
        count   <= {data, low_stage};
      end else if (tick_c) begin
        count <= divisor;
      end else begin
        count <= count - DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spart.sv
// SPART top: bus decode, 8N1 transmitter and receiver, status reporting.
// Define SPART_STATUS_ERR_EN to add sticky framing-error/overrun status bits.
module spart
  import spart_pkg::*;
#(
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd325,
  parameter int unsigned      OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned     CNT_W     = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);

  logic              wr_c, rd_c, wr_buf_c, rd_buf_c;
  logic [DATA_W-1:0] rdata_c, stat_c, rx_buf;
  logic [DIV_W-1:0]  divisor;
  logic              tick_c;

  assign wr_c     = iocs & ~iorw;
  assign rd_c     = iocs & iorw;
  assign wr_buf_c = wr_c && (ioaddr == ADDR_BUF);
  assign rd_buf_c = rd_c && (ioaddr == ADDR_BUF);

  spart_baud_gen #(.DIV_RESET(DIV_RESET)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .wr_dbl  (wr_c && (ioaddr == ADDR_DBL)),
    .wr_dbh  (wr_c && (ioaddr == ADDR_DBH)),
    .data    (databus),
    .divisor (divisor),
    .tick_c  (tick_c)
  );

  always_comb begin
    rdata_c = rx_buf;
    case (ioaddr)
      ADDR_BUF:  rdata_c = rx_buf;
      ADDR_STAT: rdata_c = stat_c;
      ADDR_DBL:  rdata_c = divisor[7:0];
      ADDR_DBH:  rdata_c = divisor[15:8];
    endcase
  end

  assign databus = rd_c ? rdata_c : 8'bz;

  // ---------------- transmitter ----------------
  tx_state_e         tx_state, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt, tx_cnt_d;
  logic [2:0]        tx_bit, tx_bit_d;
  logic [DATA_W-1:0] tx_shreg, tx_shreg_d;
  logic              txd_d, tbr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      txd      <= 1'b1;
      tbr      <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shreg <= tx_shreg_d;
      txd      <= txd_d;
      tbr      <= tbr_d;
    end
  end

  // tbr=0 while idle means a byte is latched and waiting for the next tick.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_shreg_d = tx_shreg;
    txd_d      = txd;
    tbr_d      = tbr;
    case (tx_state)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (wr_buf_c && tbr) begin
          tx_shreg_d = databus;
          tbr_d      = 1'b0;
        end else if (!tbr && tick_c) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
        end
      end
      TX_START: if (tick_c) begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shreg[0];
          tx_shreg_d = tx_shreg >> 1;
        end else begin
          tx_cnt_d = tx_cnt + CNT_W'(1);
        end
      end
      TX_DATA: if (tick_c) begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit + 3'd1;
            txd_d      = tx_shreg[0];
            tx_shreg_d = tx_shreg >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt + CNT_W'(1);
        end
      end
      TX_STOP: if (tick_c) begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
          tbr_d      = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_e         rx_state, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt, rx_cnt_d;
  logic [2:0]        rx_bit, rx_bit_d;
  logic [DATA_W-1:0] rx_shreg, rx_shreg_d;
  logic              rx_s1, rx_s2, rx_prev;
  logic              rx_done_c, frame_ok_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_shreg <= rx_shreg_d;
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
    end
  end

  // Half-bit wait in START puts every later sample near the bit centre.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_shreg_d = rx_shreg;
    rx_done_c  = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s2) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: if (tick_c) begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt + CNT_W'(1);
        end
      end
      RX_DATA: if (tick_c) begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shreg_d = {rx_s2, rx_shreg[DATA_W-1:1]};
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
          else                rx_bit_d   = rx_bit + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt + CNT_W'(1);
        end
      end
      RX_STOP: if (tick_c) begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_done_c  = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  assign frame_ok_c = rx_done_c & rx_s2;

  // A completing frame beats a same-edge buffer read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_buf <= '0;
      rda    <= 1'b0;
    end else begin
      if (frame_ok_c) rx_buf <= rx_shreg;
      if (frame_ok_c)    rda <= 1'b1;
      else if (rd_buf_c) rda <= 1'b0;
    end
  end

`ifdef SPART_STATUS_ERR_EN
  logic fe, ovr, rd_stat_c;

  assign rd_stat_c = rd_c && (ioaddr == ADDR_STAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      fe  <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (rx_done_c && !rx_s2) fe <= 1'b1;
      else if (rd_stat_c)      fe <= 1'b0;
      if (frame_ok_c && rda)   ovr <= 1'b1;
      else if (rd_stat_c)      ovr <= 1'b0;
    end
  end

  assign stat_c = {4'b0, ovr, fe, tbr, rda};
`else
  assign stat_c = {6'b0, tbr, rda};
`endif

endmodule

// File: tb/tb_spart.sv
// Randomized self-checking bench for spart with a frame-level reference model.
module tb_spart;

  localparam logic [1:0] A_BUF  = 2'b00;
  localparam logic [1:0] A_STAT = 2'b01;
  localparam logic [1:0] A_DBL  = 2'b10;
  localparam logic [1:0] A_DBH  = 2'b11;
  localparam int BIT_CLKS = 64;  // 16 ticks x 4 clocks at divisor 3

  logic       clk = 1'b0;
  logic       rst, iocs, iorw, bus_en, rxd_drv, loop_en;
  logic [1:0] ioaddr;
  logic [7:0] bus_drv;
  wire  [7:0] databus;
  wire        rxd;
  logic       rda, tbr, txd;

  assign databus = bus_en ? bus_drv : 8'bz;
  assign rxd     = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  spart dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rx;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Serial frame: start 0, data LSB first, stop bit.
  function automatic logic frame_bit(input logic [7:0] d, input int i, input logic stop);
    if (i == 0) return 1'b0;
    if (i == 9) return stop;
    return d[i-1];
  endfunction

  // Status byte as software sees it while the transmitter is idle.
  function automatic logic [7:0] stat_exp(input logic r, input logic fe, input logic ov);
`ifdef SPART_STATUS_ERR_EN
    return {4'b0, ov, fe, 1'b1, r};
`else
    return {6'b0, 1'b1, r};
`endif
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; bus_drv = d; bus_en = 1'b1;
    @(negedge clk);
    iocs = 1'b0; bus_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a; bus_en = 1'b0;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic send_raw(input logic [7:0] d, input logic stop);
    for (int i = 0; i < 10; i++) begin
      rxd_drv = frame_bit(d, i, stop);
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_loop(input logic [7:0] d);
    logic ok;
    loop_en = 1'b1;
    bus_write(A_BUF, d);
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      if (tbr) ok = 1'b1;
      else @(negedge clk);
    end
    check("loop_tx_done", ok, 1);
    repeat (4) @(negedge clk);
    loop_en = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, b;
    logic ok, stayed;
    int rise, idx;

    rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = '0; bus_drv = '0;
    bus_en = 1'b0; rxd_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_txd", txd, 1);
    check("rst_tbr", tbr, 1);
    check("rst_rda", rda, 0);
    bus_read(A_STAT, d); check("rst_stat", d, 8'h02);
    bus_read(A_BUF, d);  check("rst_rxbuf", d, 8'h00);
    bus_read(A_DBL, d);  check("rst_dbl", d, 8'h45);
    bus_read(A_DBH, d);  check("rst_dbh", d, 8'h01);

    // bus must stay released when not selected
    @(negedge clk);
    iorw = 1'b1; ioaddr = A_DBL; bus_drv = 8'h00; bus_en = 1'b1;
    #1 check("bus_released", databus, 8'h00);
    @(negedge clk);
    bus_en = 1'b0; iorw = 1'b0;

    // divisor: low byte only stages, high byte commits
    bus_write(A_DBL, 8'h03);
    bus_read(A_DBL, d); check("dbl_staged_only", d, 8'h45);
    bus_write(A_DBH, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("tick_k%0d", k), dut.u_baud.tick_c, (k % 4 == 0) ? 1 : 0);
      @(negedge clk);
    end
    bus_read(A_DBL, d); check("div_lo", d, 8'h03);
    bus_read(A_DBH, d); check("div_hi", d, 8'h00);

    // transmit 0xA5, with a dropped write mid-frame
    bus_write(A_BUF, 8'hA5);
    check("tbr_after_write", tbr, 0);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (txd == 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
    check("tx_start_latency", ok, 1);
    rise = 0;
    for (int n = 0; n <= 700; n++) begin
      if (n == 100) begin iocs = 1'b1; iorw = 1'b0; ioaddr = A_BUF; bus_drv = 8'hFF; bus_en = 1'b1; end
      if (n == 101) begin iocs = 1'b0; bus_en = 1'b0; end
      if (n >= 32 && (n - 32) % BIT_CLKS == 0 && (n - 32) / BIT_CLKS < 10) begin
        idx = (n - 32) / BIT_CLKS;
        check($sformatf("txbit%0d", idx), txd, frame_bit(8'hA5, idx, 1'b1));
        check($sformatf("tbr_busy%0d", idx), tbr, 0);
      end
      if (tbr && rise == 0) rise = n;
      @(negedge clk);
    end
    check("tx_frame_len", 16'(rise), 16'd640);
    stayed = 1'b1;
    repeat (80) begin
      if (!txd || !tbr) stayed = 1'b0;
      @(negedge clk);
    end
    check("tx_second_write_dropped", stayed, 1);

    // loopback 0x3C
    send_loop(8'h3C);
    check("loop_rda", rda, 1);
    bus_read(A_BUF, d); check("loop_data", d, 8'h3C);
    check("loop_rda_clear", rda, 0);

    // randomized loopback bytes against scoreboard
    for (int t = 0; t < 4; t++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_loop(b);
      bus_read(A_STAT, d); check($sformatf("rnd_stat%0d", t), d, stat_exp(1, 0, 0));
      bus_read(A_BUF, d);  check($sformatf("rnd_data%0d", t), d, exp_q.pop_front());
      last_rx = b;
    end

    // false start: 4-tick low pulse
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (16) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (200) @(negedge clk);
    check("false_start_rda", rda, 0);
    bus_read(A_STAT, d); check("false_start_stat", d, stat_exp(0, 0, 0));

    // framing error: stop bit 0
    send_raw(8'h5A, 1'b0);
    check("fe_rda", rda, 0);
    bus_read(A_STAT, d); check("fe_stat", d, stat_exp(0, 1, 0));
    bus_read(A_STAT, d); check("fe_stat_cleared", d, stat_exp(0, 0, 0));
    bus_read(A_BUF, d);  check("fe_buf_kept", d, last_rx);

    // overrun: two frames without reading
    send_raw(8'h11, 1'b1);
    send_raw(8'h22, 1'b1);
    check("ovr_rda", rda, 1);
    bus_read(A_STAT, d); check("ovr_stat", d, stat_exp(1, 0, 1));
    bus_read(A_BUF, d);  check("ovr_data", d, 8'h22);
    check("ovr_rda_clear", rda, 0);
    bus_read(A_STAT, d); check("ovr_stat_cleared", d, stat_exp(0, 0, 0));

    // reset mid-frame
    bus_write(A_BUF, 8'h00);
    repeat (100) @(negedge clk);
    check("mid_frame_txd", txd, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_txd", txd, 1);
    check("rst_mid_tbr", tbr, 1);
    bus_read(A_DBL, d); check("rst_mid_div", d, 8'h45);
    repeat (100) @(negedge clk);
    check("rst_mid_idle", txd, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spart.md
Name: spart

Overview:
- Serial port (SPART) that consumes the bus cycles issued by the upstream `driver` block.
- Decodes `iocs`/`iorw`/`ioaddr` accesses on the shared 8-bit tristate `databus`, holds the 16-bit baud divisor, and generates a 16x oversample tick.
- Serializes TX bytes onto `txd` and deserializes `rxd` into a receive buffer.
- Reports `tbr`/`rda` back to the driver.

Parameters:
- DIV_RESET, 16'd325, divisor value loaded at reset (ticks every DIV_RESET+1 clocks).
- OVERSAMPLE, 16, ticks per serial bit; must be even.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- iocs  input  1  chip select; access valid only when 1
- iorw  input  1  1 = read (SPART drives databus), 0 = write
- ioaddr  input  2  00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
- databus  inout  8  shared bus; SPART drives only when iocs=1 and iorw=1, else 8'bz
- rda  output  1  receive data available
- tbr  output  1  transmit buffer ready
- txd  output  1  serial out, idle high
- rxd  input  1  serial in, asynchronous

Behaviour:
- Reset values (rst sampled high at a clk edge): txd=1, tbr=1, rda=0, rx buffer=8'h00, divisor=DIV_RESET, tick counter=DIV_RESET, TX and RX FSMs in IDLE, databus=z.
- Write: takes effect at the clk edge where iocs=1 and iorw=0.
  - addr 10 stores the low staging byte; no divisor change.
  - addr 11 commits divisor={data,low staging} and reloads the tick counter on the same edge.
  - addr 00 is the TX write.
  - addr 01 write is ignored.
- Read: combinational while iocs=1 and iorw=1.
  - addr 00 returns the rx buffer.
  - addr 01 returns {6'b0,tbr,rda}.
  - addr 10/11 return the divisor low/high byte.
  - The edge at which an addr 00 read is sampled clears rda.
- Baud gen: down-counter. Emits a 1-cycle tick when the count is 0, then reloads the divisor. Divisor 0 → tick every cycle.
- TX FSM (IDLE, START, DATA, STOP):
  - An addr 00 write with tbr=1 latches the byte; tbr=0 from the next cycle.
  - Write with tbr=0 is dropped; the in-flight frame is unaffected.
  - Sequence: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts OVERSAMPLE ticks. Start bit begins at the first tick after the write.
  - tbr returns to 1 the cycle after the stop bit's last tick.
- RX FSM (IDLE, START, DATA, STOP):
  - rxd passes through a 2-flop synchronizer.
  - IDLE detects a synchronized 1→0 transition.
  - START waits OVERSAMPLE/2 ticks. If the line is 1 there (false start), return to IDLE.
  - DATA samples 8 bits, each OVERSAMPLE ticks apart, LSB first.
  - STOP samples once more. If 1: load rx buffer, rda=1 next cycle. If 0: framing error, byte discarded, rda unchanged.
- Boundary conditions:
  - Overrun (new frame completes while rda=1): buffer overwritten, rda stays 1.
  - Simultaneous read-clear and new frame completion on one edge: set wins, rda=1.
  - Divisor commit mid-frame: new rate applies from the next tick; the frame may corrupt (no protection).
  - rst mid-frame: both FSMs abort to IDLE and txd=1 on that edge.

Optional Feature:
- SPART_STATUS_ERR_EN.
- Defined:
  - Status read returns {4'b0,ovr,fe,tbr,rda}.
  - fe is set on framing error; ovr is set on overrun.
  - Both clear on a status (addr 01) read edge and on reset.
- Undefined: those bits read 0 and no flag storage is synthesized.

Decomposition:
- Package spart_pkg:
  - address constants ADDR_BUF=2'b00, ADDR_STAT=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11
  - TX/RX state encodings
  - OVERSAMPLE default
- Sub-module spart_baud_gen (divisor register, staging byte, down-counter, tick output). TX, RX and bus decode stay in spart.

Test Plan:
- Reset, then read addr 01 → 8'h02 (tbr=1, rda=0); txd=1; databus z when iocs=0.
- Write DBL=8'h03, DBH=8'h00, then read addr 10/11 → 8'h03/8'h00; ticks every 4 clocks after the DBH edge.
- Divisor 3, write 8'hA5 to addr 00 → txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 64 clocks; tbr low throughout, high after the stop bit. A second write during the frame is ignored.
- Loop txd→rxd, send 8'h3C → rda=1 after the frame; read addr 00 → 8'h3C; rda=0 next cycle.
- rxd low pulse of 4 ticks → no byte, rda=0. A frame with stop=0 → rda stays 0; with SPART_STATUS_ERR_EN, status bit 2 =1, cleared after one status read.
- Two frames 8'h11 then 8'h22 without reading → buffer 8'h22, rda=1; ovr=1 when SPART_STATUS_ERR_EN is defined.
